// File: rtl/trap_ctrl_if.sv
// Commit-boundary handshake bundle between the retire stage and trap_ctrl.
interface trap_ctrl_if #(
  parameter int unsigned DW = 64
);
  logic          commit_valid;
  logic          commit_ready;
  logic [DW-1:0] commit_pc;
  logic [DW-1:0] commit_tval;
  logic          exc_ifetch_mis;
  logic          exc_illegal;
  logic          exc_ebreak;
  logic          exc_ld_mis;
  logic          exc_st_mis;
  logic          exc_ecall;
  logic          is_mret;

  modport master (
    output commit_valid, commit_pc, commit_tval,
    output exc_ifetch_mis, exc_illegal, exc_ebreak, exc_ld_mis, exc_st_mis, exc_ecall,
    output is_mret,
    input  commit_ready
  );

  modport slave (
    input  commit_valid, commit_pc, commit_tval,
    input  exc_ifetch_mis, exc_illegal, exc_ebreak, exc_ld_mis, exc_st_mis, exc_ecall,
    input  is_mret,
    output commit_ready
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap/return sequencer: classifies each commit, produces CSR update
// strobes/data, then flushes the pipeline and issues one PC redirect.
module trap_ctrl #(
  parameter int unsigned DW          = 64,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  trap_ctrl_if.slave    cif,
  input  logic [DW-1:0] mstatus_csr_out,
  input  logic [DW-1:0] mie_csr_out,
  input  logic [DW-1:0] mip_csr_out,
  input  logic [DW-1:0] mepc_csr_out,
  input  logic [DW-1:0] mtvec_csr_out,
  output logic          isTrap,
  output logic          isXRet,
  output logic [DW-1:0] mstatus_except_in,
  output logic [DW-1:0] mcause_except_in,
  output logic [DW-1:0] mepc_except_in,
  output logic [DW-1:0] mtval_except_in,
  output logic          retire,
  output logic          flush,
  input  logic          flush_ack,
  output logic          redirect_valid,
  output logic [DW-1:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT} state_t;

  state_t        state, state_d;
  logic [DW-1:0] target_q;

  logic          accept;
  logic [DW-1:0] pend;
  logic          irq;
  logic [7:0]    irq_cause;
  logic          exc;
  logic [7:0]    exc_cause;
  logic          exc_has_tval;
  logic          trap_ev, xret_ev, retire_ev;
  logic [DW-1:0] base, vec_off, target_d;
  logic [DW-1:0] mstatus_trap, mstatus_ret;

  // Event classification and redirect target for the current commit.
  always_comb begin
    accept = cif.commit_valid & (state == IDLE) & ~RST;
    pend   = mip_csr_out & mie_csr_out & {DW{mstatus_csr_out[3]}};
    irq    = |pend;

    // Any non-standard pending bit maps to its own index; MEI > MSI > MTI override.
    irq_cause = '0;
    for (int unsigned i = DW; i > 0; i--) begin
      if (pend[i-1]) irq_cause = 8'(i - 1);
    end
    if (pend[7])  irq_cause = 8'd7;
    if (pend[3])  irq_cause = 8'd3;
    if (pend[11]) irq_cause = 8'd11;

    exc          = 1'b1;
    exc_cause    = '0;
    exc_has_tval = 1'b0;
    if (cif.exc_ifetch_mis) begin
      exc_cause = 8'd0;  exc_has_tval = 1'b1;
    end else if (cif.exc_illegal) begin
      exc_cause = 8'd2;  exc_has_tval = 1'b1;
    end else if (cif.exc_ebreak) begin
      exc_cause = 8'd3;
    end else if (cif.exc_ecall) begin
      exc_cause = 8'd11;
    end else if (cif.exc_ld_mis) begin
      exc_cause = 8'd4;  exc_has_tval = 1'b1;
    end else if (cif.exc_st_mis) begin
      exc_cause = 8'd6;  exc_has_tval = 1'b1;
    end else begin
      exc = 1'b0;
    end

    trap_ev   = accept & (irq | exc);
    xret_ev   = accept & ~irq & ~exc & cif.is_mret;
    retire_ev = accept & ~irq & ~exc & ~cif.is_mret;

    base          = {mtvec_csr_out[DW-1:2], 2'b00};
    vec_off       = '0;
    vec_off[9:0]  = {irq_cause, 2'b00};
    if (xret_ev)
      target_d = mepc_csr_out;
    else if (VECTORED_EN && (mtvec_csr_out[1:0] == 2'b01) && irq)
      target_d = base + vec_off;
    else
      target_d = base;

    mstatus_trap        = mstatus_csr_out;
    mstatus_trap[7]     = mstatus_csr_out[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;

    mstatus_ret         = mstatus_csr_out;
    mstatus_ret[3]      = mstatus_csr_out[7];
    mstatus_ret[7]      = 1'b1;
    mstatus_ret[12:11]  = 2'b11;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      target_q <= '0;
    end else begin
      state <= state_d;
      if (trap_ev || xret_ev) target_q <= target_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (trap_ev || xret_ev) state_d = DRAIN;
      DRAIN:    if (flush_ack) state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cif.commit_ready  = (state == IDLE) & ~RST;
    flush             = (state == DRAIN);
    redirect_valid    = (state == REDIRECT);
    redirect_pc       = (state == REDIRECT) ? target_q : '0;
    retire            = retire_ev;
    isTrap            = trap_ev;
    isXRet            = xret_ev;
    mstatus_except_in = '0;
    mcause_except_in  = '0;
    mepc_except_in    = '0;
    mtval_except_in   = '0;
    if (trap_ev) begin
      mstatus_except_in = mstatus_trap;
      mepc_except_in    = cif.commit_pc;
      mcause_except_in[DW-1] = irq;
      mcause_except_in[7:0]  = irq ? irq_cause : exc_cause;
      if (!irq && exc_has_tval) mtval_except_in = cif.commit_tval;
    end else if (xret_ev) begin
      mstatus_except_in = mstatus_ret;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus queues expected strobes/redirects, a monitor checks them.
module tb_trap_ctrl;
  localparam int unsigned DW = 64;
  localparam int K_RET = 0, K_TRAP = 1, K_XRET = 2, K_REDIR = 3;

  logic          CLK, RST;
  logic [DW-1:0] mstatus_csr_out, mie_csr_out, mip_csr_out, mepc_csr_out, mtvec_csr_out;
  logic          isTrap, isXRet, retire, flush, flush_ack, redirect_valid;
  logic [DW-1:0] mstatus_except_in, mcause_except_in, mepc_except_in, mtval_except_in;
  logic [DW-1:0] redirect_pc;

  trap_ctrl_if #(.DW(DW)) cif ();

  trap_ctrl #(.DW(DW), .VECTORED_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST), .cif(cif.slave),
    .mstatus_csr_out(mstatus_csr_out), .mie_csr_out(mie_csr_out), .mip_csr_out(mip_csr_out),
    .mepc_csr_out(mepc_csr_out), .mtvec_csr_out(mtvec_csr_out),
    .isTrap(isTrap), .isXRet(isXRet),
    .mstatus_except_in(mstatus_except_in), .mcause_except_in(mcause_except_in),
    .mepc_except_in(mepc_except_in), .mtval_except_in(mtval_except_in),
    .retire(retire), .flush(flush), .flush_ack(flush_ack),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct {
    int          kind;
    logic [63:0] ms, mc, me, mt, pc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  function automatic void push(int kind, logic [63:0] ms, logic [63:0] mc,
                               logic [63:0] me, logic [63:0] mt, logic [63:0] pc);
    exp_t e;
    e.kind = kind; e.ms = ms; e.mc = mc; e.me = me; e.mt = mt; e.pc = pc;
    q.push_back(e);
  endfunction

  function automatic void pop_cmp(int kind);
    exp_t e;
    if (q.size() == 0) begin
      chk("unexpected_event", 64'(kind), 64'hFFFF);
      return;
    end
    e = q.pop_front();
    chk("event_kind", 64'(kind), 64'(e.kind));
    if (e.kind != kind) return;
    case (kind)
      K_TRAP: begin
        chk("trap_mstatus", mstatus_except_in, e.ms);
        chk("trap_mcause", mcause_except_in, e.mc);
        chk("trap_mepc", mepc_except_in, e.me);
        chk("trap_mtval", mtval_except_in, e.mt);
      end
      K_XRET:  chk("xret_mstatus", mstatus_except_in, e.ms);
      K_REDIR: chk("redirect_pc", redirect_pc, e.pc);
      default: ;
    endcase
  endfunction

  // Monitor: every observed strobe must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (!RST) begin
      if (retire)         pop_cmp(K_RET);
      if (isTrap)         pop_cmp(K_TRAP);
      if (isXRet)         pop_cmp(K_XRET);
      if (redirect_valid) pop_cmp(K_REDIR);
    end
  end

  task automatic clear_in();
    cif.commit_valid   = 1'b0;
    cif.exc_ifetch_mis = 1'b0;
    cif.exc_illegal    = 1'b0;
    cif.exc_ebreak     = 1'b0;
    cif.exc_ld_mis     = 1'b0;
    cif.exc_st_mis     = 1'b0;
    cif.exc_ecall      = 1'b0;
    cif.is_mret        = 1'b0;
  endtask

  task automatic do_commit();
    cif.commit_valid = 1'b1;
    @(posedge CLK); #1;
    clear_in();
  endtask

  task automatic drain(int hold);
    chk("flush_on", 64'(flush), 64'd1);
    chk("ready_in_drain", 64'(cif.commit_ready), 64'd0);
    repeat (hold) begin
      @(posedge CLK); #1;
      chk("flush_held", 64'(flush), 64'd1);
    end
    flush_ack = 1'b1;
    @(posedge CLK); #1;
    flush_ack = 1'b0;
    chk("flush_drop", 64'(flush), 64'd0);
    @(posedge CLK); #1;
    chk("ready_back", 64'(cif.commit_ready), 64'd1);
    chk("redirect_one_cycle", 64'(redirect_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=0", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1; flush_ack = 1'b0;
    mstatus_csr_out = '0; mie_csr_out = '0; mip_csr_out = '0; mepc_csr_out = '0; mtvec_csr_out = '0;
    cif.commit_pc = '0; cif.commit_tval = '0;
    clear_in();
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    chk("rst_ready", 64'(cif.commit_ready), 64'd1);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_redirect", 64'(redirect_valid), 64'd0);
    chk("rst_redirect_pc", redirect_pc, 64'd0);
    chk("rst_strobes", {61'd0, isTrap, isXRet, retire}, 64'd0);

    // Normal retire
    cif.commit_pc = 64'h8000_0000;
    push(K_RET, 0, 0, 0, 0, 0);
    cif.commit_valid = 1'b1; #1;
    chk("ready_with_valid", 64'(cif.commit_ready), 64'd1);
    @(posedge CLK); #1; clear_in();
    chk("retire_no_flush", 64'(flush), 64'd0);
    chk("retire_ready", 64'(cif.commit_ready), 64'd1);

    // Illegal + ecall: illegal wins, mtval carries tval
    cif.commit_pc = 64'h8000_0010; cif.commit_tval = 64'hDEAD;
    mstatus_csr_out = 64'h8; mtvec_csr_out = 64'h8000_0100;
    cif.exc_illegal = 1'b1; cif.exc_ecall = 1'b1;
    push(K_TRAP, 64'h1880, 64'd2, 64'h8000_0010, 64'hDEAD, 0);
    push(K_REDIR, 0, 0, 0, 0, 64'h8000_0100);
    do_commit(); drain(2);

    // Vectored timer interrupt beats ld_mis
    cif.commit_pc = 64'h8000_0040; cif.commit_tval = 64'h1234;
    mtvec_csr_out = 64'h8000_0101; mip_csr_out = 64'h80; mie_csr_out = 64'h80;
    cif.exc_ld_mis = 1'b1;
    push(K_TRAP, 64'h1880, 64'h8000_0000_0000_0007, 64'h8000_0040, 64'd0, 0);
    push(K_REDIR, 0, 0, 0, 0, 64'h8000_011C);
    do_commit(); drain(0);

    // MEI > MSI > MTI
    cif.commit_pc = 64'h8000_0050;
    mip_csr_out = 64'h888; mie_csr_out = 64'h888;
    push(K_TRAP, 64'h1880, 64'h8000_0000_0000_000B, 64'h8000_0050, 64'd0, 0);
    push(K_REDIR, 0, 0, 0, 0, 64'h8000_012C);
    do_commit(); drain(1);

    // Same pending set with MIE=0 retires normally
    mstatus_csr_out = 64'h0;
    push(K_RET, 0, 0, 0, 0, 0);
    do_commit();
    chk("masked_irq_no_flush", 64'(flush), 64'd0);

    // mret
    mip_csr_out = '0; mie_csr_out = '0;
    mstatus_csr_out = 64'h80; mepc_csr_out = 64'h8000_2000; cif.is_mret = 1'b1;
    push(K_XRET, 64'h1888, 0, 0, 0, 0);
    push(K_REDIR, 0, 0, 0, 0, 64'h8000_2000);
    do_commit(); drain(1);

    // MSI with mtvec MODE=2 behaves as direct
    cif.commit_pc = 64'h8000_0058;
    mstatus_csr_out = 64'h88; mtvec_csr_out = 64'h8000_0102;
    mip_csr_out = 64'h8; mie_csr_out = 64'h8;
    push(K_TRAP, 64'h1880, 64'h8000_0000_0000_0003, 64'h8000_0058, 64'd0, 0);
    push(K_REDIR, 0, 0, 0, 0, 64'h8000_0100);
    do_commit(); drain(0);

    // ebreak beats ld/st_mis, no mtval; exceptions ignore vectored mode
    mip_csr_out = '0; mie_csr_out = '0;
    cif.commit_pc = 64'h8000_0060; cif.commit_tval = 64'h77;
    mstatus_csr_out = 64'h0; mtvec_csr_out = 64'h8000_0101;
    cif.exc_ebreak = 1'b1; cif.exc_ld_mis = 1'b1; cif.exc_st_mis = 1'b1;
    push(K_TRAP, 64'h1800, 64'd3, 64'h8000_0060, 64'd0, 0);
    push(K_REDIR, 0, 0, 0, 0, 64'h8000_0100);
    do_commit(); drain(0);

    // st_mis alone
    cif.commit_pc = 64'h8000_0070; cif.commit_tval = 64'hBEEF;
    mstatus_csr_out = 64'h1808; cif.exc_st_mis = 1'b1;
    push(K_TRAP, 64'h1880, 64'd6, 64'h8000_0070, 64'hBEEF, 0);
    push(K_REDIR, 0, 0, 0, 0, 64'h8000_0100);
    do_commit(); drain(0);

    // ifetch_mis beats illegal
    cif.commit_pc = 64'h8000_0074; cif.commit_tval = 64'h8000_0002;
    mstatus_csr_out = 64'h0; cif.exc_ifetch_mis = 1'b1; cif.exc_illegal = 1'b1;
    push(K_TRAP, 64'h1800, 64'd0, 64'h8000_0074, 64'h8000_0002, 0);
    push(K_REDIR, 0, 0, 0, 0, 64'h8000_0100);
    do_commit(); drain(0);

    // flush_ack in IDLE and pending interrupt without a commit: no action
    mstatus_csr_out = 64'h8; mip_csr_out = 64'h80; mie_csr_out = 64'h80;
    flush_ack = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
      chk("idle_ack_no_flush", 64'(flush), 64'd0);
      chk("idle_ack_ready", 64'(cif.commit_ready), 64'd1);
    end
    flush_ack = 1'b0;
    mip_csr_out = '0; mie_csr_out = '0;

    // Reset during DRAIN: flush drops, no redirect
    cif.commit_pc = 64'h8000_0080; cif.exc_ecall = 1'b1;
    push(K_TRAP, 64'h1880, 64'd11, 64'h8000_0080, 64'd0, 0);
    do_commit();
    chk("pre_rst_flush", 64'(flush), 64'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("rst_drain_flush", 64'(flush), 64'd0);
    RST = 1'b0; #1;
    chk("rst_drain_ready", 64'(cif.commit_ready), 64'd1);
    repeat (3) begin
      @(posedge CLK); #1;
      chk("rst_drain_no_redirect", 64'(redirect_valid), 64'd0);
    end

    // Minimum 3-cycle turnaround with flush_ack already high
    mstatus_csr_out = 64'h0; mepc_csr_out = 64'h8000_3000;
    flush_ack = 1'b1; cif.is_mret = 1'b1;
    push(K_XRET, 64'h1880, 0, 0, 0, 0);
    push(K_REDIR, 0, 0, 0, 0, 64'h8000_3000);
    push(K_RET, 0, 0, 0, 0, 0);
    do_commit();
    cif.commit_valid = 1'b1;
    chk("turn_ready_e0", 64'(cif.commit_ready), 64'd0);
    @(posedge CLK); #1;
    chk("turn_ready_e1", 64'(cif.commit_ready), 64'd0);
    @(posedge CLK); #1;
    chk("turn_ready_e2", 64'(cif.commit_ready), 64'd1);
    @(posedge CLK); #1;
    clear_in(); flush_ack = 1'b0;

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge CLK);
    @(posedge CLK); #1;
    chk("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
